// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state type and request legality check shared by the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} lsu_state_t;

    // 011, 11x are never legal; stores have no unsigned variants
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3 > F3_W);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core-side request/response bundle of the load/store controller
// master = core (drives req_*), slave = lsu_ctrl (drives req_ready and rsp_*)
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane extract/extend for loads and lane merge for sub-word stores
// ports: funct3, off (addr[1:0]), rword (memory word), wdata (right-aligned store data)
//        -> ldata (extended load value), mdata (word to write back)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    // funct3[1] = word, funct3[0] = half, funct3[2] = unsigned
    always_comb begin
        sh    = {off, 3'b000};
        b     = 8'(rword >> sh);
        h     = off[1] ? rword[31:16] : rword[15:0];
        sx    = !funct3[2];
        ldata = funct3[1] ? rword
              : funct3[0] ? {{16{sx & h[15]}}, h}
              : {{24{sx & b[7]}}, b};
        mdata = funct3[1] ? wdata
              : funct3[0] ? (off[1] ? {wdata[15:0], rword[15:0]} : {rword[31:16], wdata[15:0]})
              : (rword & ~(32'hFF << sh)) | ({24'b0, wdata[7:0]} << sh);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller on a word-wide synchronous RAM (RMW for sub-word stores)
// ports: clk, rst_n (async, active-low), bus (lsu_if.slave request/response),
//        mem_addr/mem_we/mem_wdata to the decoder, mem_rdata valid RD_LAT (1..2) cycles after mem_addr
// option: MISALIGN_TRAP_EN makes misaligned H/W accesses errors instead of clearing the low address bits
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        bus,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_n;
    logic [31:0] addr_q, wdata_q, aligned, ldata, mdata;
    logic [2:0]  f3_q;
    logic [1:0]  cnt;
    logic        we_q, accept, err, rd_done;

    assign accept  = bus.req_valid && bus.req_ready;
    assign rd_done = cnt == 2'(RD_LAT - 1);
    assign mem_addr = {addr_q[31:2], 2'b00};

    // halfwords drop addr[0], words drop addr[1:0]; a no-op on accesses that are already aligned
    assign aligned = {bus.req_addr[31:2],
                      bus.req_funct3[1] ? 2'b00 : {bus.req_addr[1], bus.req_addr[0] & ~bus.req_funct3[0]}};

`ifdef MISALIGN_TRAP_EN
    assign err = f3_illegal(bus.req_we, bus.req_funct3) ||
                 (bus.req_funct3[1] ? |bus.req_addr[1:0] : bus.req_funct3[0] & bus.req_addr[0]);
`else
    assign err = f3_illegal(bus.req_we, bus.req_funct3);
`endif

    lsu_align u_align (
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .rword  (mem_rdata),
        .wdata  (wdata_q),
        .ldata  (ldata),
        .mdata  (mdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = err ? RESP : (bus.req_we && bus.req_funct3 == F3_W) ? WRITE : RD_WAIT;
            RD_WAIT: if (rd_done) state_n = we_q ? WRITE : RESP;
            WRITE:   state_n = RESP;
            RESP:    state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        mem_we        = state == WRITE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            f3_q          <= '0;
            we_q          <= 1'b0;
            cnt           <= '0;
            mem_wdata     <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            cnt <= state == RD_WAIT ? cnt + 2'd1 : 2'd0;
            if (accept) begin
                addr_q  <= aligned;
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_funct3;
                we_q    <= bus.req_we;
                // SW goes straight to WRITE with the data as-is; sub-word stores overwrite this after the read
                if (bus.req_we)
                    mem_wdata <= bus.req_wdata;
                if (err) begin
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b1;
                end
            end
            if (state == RD_WAIT && rd_done) begin
                if (we_q)
                    mem_wdata <= mdata;
                else begin
                    bus.rsp_rdata <= ldata;
                    bus.rsp_err   <= 1'b0;
                end
            end
            if (state == WRITE) begin
                bus.rsp_rdata <= '0;
                bus.rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl at RD_LAT=1 (u1) and RD_LAT=2 (u2) driven in lockstep
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;

    lsu_if b1();
    lsu_if b2();
    assign b1.req_valid = req_valid;
    assign b1.req_we = req_we;
    assign b1.req_funct3 = req_funct3;
    assign b1.req_addr = req_addr;
    assign b1.req_wdata = req_wdata;
    assign b2.req_valid = req_valid;
    assign b2.req_we = req_we;
    assign b2.req_funct3 = req_funct3;
    assign b2.req_addr = req_addr;
    assign b2.req_wdata = req_wdata;

    logic [31:0] a1, a2, wd1, wd2, rd1, rd2, q2;
    logic        we1, we2;
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_data = '0;

    lsu_ctrl #(.RD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .mem_addr(a1), .mem_we(we1), .mem_wdata(wd1), .mem_rdata(rd1));
    lsu_ctrl #(.RD_LAT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2), .mem_addr(a2), .mem_we(we2), .mem_wdata(wd2), .mem_rdata(rd2));

    // latency 1: word visible within the address cycle; latency 2: one extra register stage
    assign rd1 = mem1[a1[9:2]];
    assign rd2 = q2;

    always @(posedge clk) begin
        q2 <= mem2[a2[9:2]];
        if (poke_en) begin
            mem1[poke_idx] <= poke_data;
            mem2[poke_idx] <= poke_data;
        end else begin
            if (we1) mem1[a1[9:2]] <= wd1;
            if (we2) mem2[a2[9:2]] <= wd2;
        end
    end

    int checks = 0;
    int failures = 0;

    int          rv_cyc [2], rv_cnt [2], we_cyc [2], we_cnt [2], rdy_cyc [2];
    logic [31:0] rv_data [2], we_data [2];
    logic        rv_err [2];

    task automatic poke(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_idx = idx;
        poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic sample(input int i, input int c, input logic rv, input logic [31:0] rd, input logic e,
                          input logic mw, input logic [31:0] wd, input logic rdy);
        if (rv) begin
            rv_cnt[i]++;
            if (rv_cyc[i] == 0) rv_cyc[i] = c;
            rv_data[i] = rd;
            rv_err[i] = e;
        end
        if (mw) begin
            we_cnt[i]++;
            if (we_cyc[i] == 0) we_cyc[i] = c;
            we_data[i] = wd;
        end
        if (rdy && rdy_cyc[i] == 0) rdy_cyc[i] = c;
    endtask

    // one request to both DUTs; records what each does in cycles T+1..T+8
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < 2; i++) begin
            rv_cyc[i] = 0; rv_cnt[i] = 0; we_cyc[i] = 0; we_cnt[i] = 0; rdy_cyc[i] = 0;
            rv_data[i] = 'x; we_data[i] = 'x; rv_err[i] = 1'bx;
        end
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            sample(0, c, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err, we1, wd1, b1.req_ready);
            sample(1, c, b2.rsp_valid, b2.rsp_rdata, b2.rsp_err, we2, wd2, b2.req_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (b1.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", b1.req_ready); end
        checks++; if (b1.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", b1.rsp_valid); end
        checks++; if (b1.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata: got %h want 0", b1.rsp_rdata); end
        checks++; if (b1.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b want 0", b1.rsp_err); end
        checks++; if (we1 !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", we1); end
        checks++; if (a1 !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", a1); end
        checks++; if (wd1 !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", wd1); end
        checks++; if (b2.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready_l2: got %b want 1", b2.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw;
        poke(8'hC0, 32'h8899AABB);
        run(1'b0, F3_W, 32'h300, 32'h0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (rv_cyc[i] != 2 + i) begin failures++; $display("FAIL lw_rsp_cycle[L=%0d]: got %0d want %0d", i + 1, rv_cyc[i], 2 + i); end
            checks++; if (rv_cnt[i] != 1) begin failures++; $display("FAIL lw_rsp_count[L=%0d]: got %0d want 1", i + 1, rv_cnt[i]); end
            checks++; if (rv_data[i] !== 32'h8899AABB) begin failures++; $display("FAIL lw_rdata[L=%0d]: got %h want 8899aabb", i + 1, rv_data[i]); end
            checks++; if (rv_err[i] !== 1'b0) begin failures++; $display("FAIL lw_err[L=%0d]: got %b want 0", i + 1, rv_err[i]); end
            checks++; if (we_cnt[i] != 0) begin failures++; $display("FAIL lw_no_write[L=%0d]: got %0d want 0", i + 1, we_cnt[i]); end
            checks++; if (rdy_cyc[i] != 3 + i) begin failures++; $display("FAIL lw_ready_cycle[L=%0d]: got %0d want %0d", i + 1, rdy_cyc[i], 3 + i); end
        end
    endtask

    task automatic test_subword_load;
        logic [2:0]  f3 [4]  = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] ad [4]  = '{32'h303, 32'h303, 32'h302, 32'h300};
        logic [31:0] ex [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233};
        poke(8'hC0, 32'h80112233);
        for (int k = 0; k < 4; k++) begin
            run(1'b0, f3[k], ad[k], 32'h0);
            for (int i = 0; i < 2; i++) begin
                checks++; if (rv_data[i] !== ex[k]) begin failures++; $display("FAIL load_ext[%0d,L=%0d]: got %h want %h", k, i + 1, rv_data[i], ex[k]); end
                checks++; if (rv_cyc[i] != 2 + i) begin failures++; $display("FAIL load_cycle[%0d,L=%0d]: got %0d want %0d", k, i + 1, rv_cyc[i], 2 + i); end
            end
        end
    endtask

    task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, input int rmw);
        poke(addr[9:2], 32'h11223344);
        run(1'b1, f3, addr, wdata);
        for (int i = 0; i < 2; i++) begin
            checks++; if (we_cnt[i] != 1) begin failures++; $display("FAIL st_we_count[f3=%0d,L=%0d]: got %0d want 1", f3, i + 1, we_cnt[i]); end
            checks++; if (we_cyc[i] != 1 + rmw * (i + 1)) begin failures++; $display("FAIL st_we_cycle[f3=%0d,L=%0d]: got %0d want %0d", f3, i + 1, we_cyc[i], 1 + rmw * (i + 1)); end
            checks++; if (we_data[i] !== exp) begin failures++; $display("FAIL st_wdata[f3=%0d,L=%0d]: got %h want %h", f3, i + 1, we_data[i], exp); end
            checks++; if (rv_cyc[i] != 2 + rmw * (i + 1)) begin failures++; $display("FAIL st_rsp_cycle[f3=%0d,L=%0d]: got %0d want %0d", f3, i + 1, rv_cyc[i], 2 + rmw * (i + 1)); end
            checks++; if (rv_data[i] !== 32'h0 || rv_err[i] !== 1'b0) begin failures++; $display("FAIL st_rsp[f3=%0d,L=%0d]: got %h/%b want 0/0", f3, i + 1, rv_data[i], rv_err[i]); end
        end
        checks++; if (mem1[addr[9:2]] !== exp || mem2[addr[9:2]] !== exp) begin failures++; $display("FAIL st_mem[f3=%0d]: got %h/%h want %h", f3, mem1[addr[9:2]], mem2[addr[9:2]], exp); end
    endtask

    task automatic test_error;
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3 [4] = '{3'b011, F3_BU, 3'b111, 3'b110};
        for (int k = 0; k < 4; k++) begin
            poke(8'hC0, 32'h8899AABB);
            run(1'b0, F3_W, 32'h300, 32'h0);
            run(we[k], f3[k], 32'h300, 32'h12345678);
            for (int i = 0; i < 2; i++) begin
                checks++; if (rv_cyc[i] != 1) begin failures++; $display("FAIL err_cycle[%0d,L=%0d]: got %0d want 1", k, i + 1, rv_cyc[i]); end
                checks++; if (rv_err[i] !== 1'b1 || rv_data[i] !== 32'h0) begin failures++; $display("FAIL err_rsp[%0d,L=%0d]: got %b/%h want 1/0", k, i + 1, rv_err[i], rv_data[i]); end
                checks++; if (we_cnt[i] != 0) begin failures++; $display("FAIL err_no_write[%0d,L=%0d]: got %0d want 0", k, i + 1, we_cnt[i]); end
                checks++; if (rdy_cyc[i] != 2) begin failures++; $display("FAIL err_ready[%0d,L=%0d]: got %0d want 2", k, i + 1, rdy_cyc[i]); end
            end
        end
        checks++; if (mem1[8'hC0] !== 32'h8899AABB) begin failures++; $display("FAIL err_mem: got %h want 8899aabb", mem1[8'hC0]); end
    endtask

    task automatic test_misalign;
        poke(8'hC0, 32'hA1B2C3D4);
        run(1'b0, F3_W, 32'h301, 32'h0);
        for (int i = 0; i < 2; i++) begin
`ifdef MISALIGN_TRAP_EN
            checks++; if (rv_cyc[i] != 1) begin failures++; $display("FAIL mis_lw_cycle[L=%0d]: got %0d want 1", i + 1, rv_cyc[i]); end
            checks++; if (rv_err[i] !== 1'b1 || rv_data[i] !== 32'h0) begin failures++; $display("FAIL mis_lw_rsp[L=%0d]: got %b/%h want 1/0", i + 1, rv_err[i], rv_data[i]); end
`else
            checks++; if (rv_cyc[i] != 2 + i) begin failures++; $display("FAIL mis_lw_cycle[L=%0d]: got %0d want %0d", i + 1, rv_cyc[i], 2 + i); end
            checks++; if (rv_err[i] !== 1'b0 || rv_data[i] !== 32'hA1B2C3D4) begin failures++; $display("FAIL mis_lw_rsp[L=%0d]: got %b/%h want 0/a1b2c3d4", i + 1, rv_err[i], rv_data[i]); end
`endif
        end
`ifndef MISALIGN_TRAP_EN
        checks++; if (a1 !== 32'h300) begin failures++; $display("FAIL mis_lw_addr: got %h want 00000300", a1); end
`endif
        run(1'b0, F3_H, 32'h303, 32'h0);
`ifdef MISALIGN_TRAP_EN
        checks++; if (rv_cyc[0] != 1 || rv_err[0] !== 1'b1) begin failures++; $display("FAIL mis_lh: got cyc %0d err %b want 1/1", rv_cyc[0], rv_err[0]); end
`else
        checks++; if (rv_data[0] !== 32'hFFFFA1B2 || rv_err[0] !== 1'b0) begin failures++; $display("FAIL mis_lh: got %h/%b want ffffa1b2/0", rv_data[0], rv_err[0]); end
`endif
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int busy = 0;
        poke(8'hC0, 32'h11223344);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h301; req_wdata = 32'hEE; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (we1 !== 1'b1) begin failures++; $display("FAIL rstmid_in_write: got %b want 1", we1); end
        rst_n = 1'b0;
        #1;
        checks++; if (we1 !== 1'b0 || we2 !== 1'b0) begin failures++; $display("FAIL rstmid_we_drop: got %b/%b want 0/0", we1, we2); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b1.rsp_valid || b2.rsp_valid) seen++;
            if (!b1.req_ready || !b2.req_ready) busy++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_no_rsp: got %0d want 0", seen); end
        checks++; if (busy != 0) begin failures++; $display("FAIL rstmid_ready: got %0d busy cycles want 0", busy); end
        checks++; if (mem1[8'hC0] !== 32'h11223344 || mem2[8'hC0] !== 32'h11223344) begin failures++; $display("FAIL rstmid_mem: got %h/%h want 11223344", mem1[8'hC0], mem2[8'hC0]); end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_subword_load;
        test_store(F3_B, 32'h301, 32'h000000EE, 32'h1122EE44, 1);
        test_store(F3_H, 32'h302, 32'h1234BEEF, 32'hBEEF3344, 1);
        test_store(F3_H, 32'h300, 32'h0000BEEF, 32'h1122BEEF, 1);
        test_store(F3_W, 32'h304, 32'hCAFEF00D, 32'hCAFEF00D, 0);
        test_error;
        test_misalign;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
